// File: rtl/prog_engine_pkg.sv
// Shared types and instruction field positions for the prog_engine block.
package prog_engine_pkg;

  localparam int OPC_MSB = 19;
  localparam int A_MSB   = 15;
  localparam int B_MSB   = 7;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JNZ  = 4'h9,
    OP_DEC  = 4'hA,
    OP_OUT  = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OPC  = 2'd1,
    ERR_PC   = 2'd2,
    ERR_WDOG = 2'd3
  } err_e;

endpackage

// File: rtl/prog_engine_if.sv
// Control, preload and result-stream signals of prog_engine; master = host, slave = engine.
interface prog_engine_if #(
  parameter int WIDTH     = 16,
  parameter int INSTR_LEN = 20,
  parameter int ADDR      = 5
);
  logic                 go;
  logic                 wr_en;
  logic [ADDR-1:0]      wr_addr;
  logic [INSTR_LEN-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           err_code;
  logic [WIDTH-1:0]     result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output go, wr_en, wr_addr, wr_data, result_ready,
    input  busy, done, error, err_code, result, result_valid
  );

  modport slave (
    input  go, wr_en, wr_addr, wr_data, result_ready,
    output busy, done, error, err_code, result, result_valid
  );
endinterface

// File: rtl/prog_engine_instr_mem.sv
// 1R1W instruction memory: synchronous write, registered read (old data on same-address write).
module instr_mem #(
  parameter int INSTR_LEN = 20,
  parameter int ADDR      = 5,
  parameter int PROG_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR-1:0]      wr_addr,
  input  logic [INSTR_LEN-1:0] wr_data,
  input  logic [ADDR-1:0]      rd_addr,
  output logic [INSTR_LEN-1:0] rd_data
);
  localparam int AW = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1;

  logic [INSTR_LEN-1:0] mem [PROG_LEN];

  // Addresses past PROG_LEN have no backing word: writes drop, reads give zero.
  always_ff @(posedge clk) begin
    if (we && int'(wr_addr) < PROG_LEN) mem[wr_addr[AW-1:0]] <= wr_data;
    rd_data <= (int'(rd_addr) < PROG_LEN) ? mem[rd_addr[AW-1:0]] : '0;
  end
endmodule

// File: rtl/prog_engine.sv
// Multi-cycle fetch/execute engine: FSM, register file and ALU around a preloadable
// instruction memory, with a valid/ready result stream and termination error codes.
import prog_engine_pkg::*;

module prog_engine #(
  parameter int WIDTH     = 16,
  parameter int INSTR_LEN = 20,
  parameter int ADDR      = 5,
  parameter int PROG_LEN  = 32,
  parameter int NREG      = 4,
  parameter int MAX_STEPS = 1024
) (
  input logic          clk,
  input logic          reset,
  prog_engine_if.slave bus
);
  localparam int RIDX = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SW   = $clog2(MAX_STEPS + 1);
  localparam logic [ADDR:0] PC_END = (ADDR+1)'(PROG_LEN);

  state_e state, state_nxt;
  err_e   err_nxt;

  logic [ADDR-1:0]            pc;
  logic [SW-1:0]              steps;
  logic [NREG-1:0][WIDTH-1:0] regs;
  logic [INSTR_LEN-1:0]       rd_data;

  logic             busy, mem_we, done, error, result_valid;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] result;

  logic [3:0]       opc;
  logic [7:0]       fa, fb;
  logic [RIDX-1:0]  ra, rb;
  logic [WIDTH-1:0] opa, opb, alu;
  logic             reg_we, bad_opc, wdog, accept;
  logic [ADDR:0]    npc, pc_inc;
  logic             unused_a_hi;

  instr_mem #(.INSTR_LEN(INSTR_LEN), .ADDR(ADDR), .PROG_LEN(PROG_LEN)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  assign opc         = rd_data[OPC_MSB -: 4];
  assign fa          = rd_data[A_MSB -: 8];
  assign fb          = rd_data[B_MSB -: 8];
  assign ra          = fa[RIDX-1:0];
  assign rb          = fb[RIDX-1:0];
  // Only the low RIDX bits of A select a register; the rest is don't-care.
  assign unused_a_hi = ^fa[7:RIDX];
  assign opa         = regs[ra];
  assign opb         = regs[rb];
  assign wdog        = (steps == SW'(MAX_STEPS));
  assign bad_opc     = (opc == 4'hC) || (opc == 4'hD) || (opc == 4'hE);
  assign accept      = ((state == S_IDLE) || (state == S_DONE)) && bus.go;
  assign pc_inc      = (ADDR+1)'(pc) + (ADDR+1)'(1);

  always_comb begin
    alu    = opa;
    reg_we = 1'b0;
    npc    = pc_inc;
    case (opc)
      OP_LDI: begin alu = WIDTH'(fb);            reg_we = 1'b1; end
      OP_ADD: begin alu = opa + opb;             reg_we = 1'b1; end
      OP_SUB: begin alu = opa - opb;             reg_we = 1'b1; end
      OP_AND: begin alu = opa & opb;             reg_we = 1'b1; end
      OP_OR:  begin alu = opa | opb;             reg_we = 1'b1; end
      OP_XOR: begin alu = opa ^ opb;             reg_we = 1'b1; end
      OP_SHL: begin alu = opa << fb[3:0];        reg_we = 1'b1; end
      OP_DEC: begin alu = opa - WIDTH'(1);       reg_we = 1'b1; end
      OP_JMP: npc = {1'b0, fb[ADDR-1:0]};
      OP_JNZ: if (opa != '0) npc = {1'b0, fb[ADDR-1:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Watchdog is checked before decode so the overflowing instruction never executes.
  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    case (state)
      S_IDLE, S_DONE: if (bus.go) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (wdog) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_WDOG;
        end else if (opc == OP_HALT) begin
          state_nxt = S_DONE;
        end else if (bad_opc) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_OPC;
        end else if (opc == OP_OUT) begin
          state_nxt = S_OUT_WAIT;
        end else if (npc >= PC_END) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_PC;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_OUT_WAIT: begin
        if (bus.result_ready) begin
          if (pc_inc >= PC_END) begin
            state_nxt = S_DONE;
            err_nxt   = ERR_PC;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_OUT_WAIT);
    mem_we = bus.wr_en && !busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= '0;
      steps        <= '0;
      regs         <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (accept) begin
        pc       <= '0;
        steps    <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
        err_code <= '0;
      end
      if (state == S_EXEC && !wdog) begin
        steps <= steps + SW'(1);
        if (reg_we) regs[ra] <= alu;
        if (opc == OP_OUT) begin
          result       <= opa;
          result_valid <= 1'b1;
        end
        if (state_nxt == S_FETCH) pc <= npc[ADDR-1:0];
      end
      // The handshake cycle itself advances pc; valid falls on the next edge.
      if (state == S_OUT_WAIT && bus.result_ready) begin
        result_valid <= 1'b0;
        if (state_nxt == S_FETCH) pc <= pc_inc[ADDR-1:0];
      end
      if (state_nxt == S_DONE && state != S_DONE) begin
        done     <= 1'b1;
        error    <= (err_nxt != ERR_NONE);
        err_code <= err_nxt;
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.err_code     = err_code;
  assign bus.result       = result;
  assign bus.result_valid = result_valid;

endmodule
